// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store sequencer that splits byte/half/word accesses into
//               legal word or single-byte memory cycles and extends load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W       = 32,
  parameter bit FAST_ALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              mem_we,
  output logic              mem_be,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ0 = 3'd2,
    S_READ1 = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_k;
  logic              r_fast;
  logic [31:0]       r_word0;
  logic              r_mem_we;
  logic              r_mem_be;
  logic [ADDR_W-1:0] r_mem_a;
  logic [31:0]       r_mem_wd;
  logic              r_done;
  logic [31:0]       r_rdata;

  logic [1:0]        w_last;
  logic [1:0]        w_k_next;
  logic              w_span;

  // Index of the last byte of an access: 0 for byte, 1 for half, 3 for word.
  function automatic logic [1:0] last_idx(input logic [1:0] s);
    case (s)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [63:0] dw, input logic [1:0] off,
                                          input logic [1:0] s, input logic u);
    logic [31:0] sh;
    sh = dw[{1'b0, off, 3'b000} +: 32];
    case (s)
      2'b00:   extract = u ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = u ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  assign w_last   = last_idx(r_size);
  assign w_k_next = r_k + 2'd1;
  assign w_span   = ({1'b0, r_addr[1:0]} + {1'b0, w_last}) > 3'd3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_size   <= 2'b00;
      r_uns    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_k      <= 2'd0;
      r_fast   <= 1'b0;
      r_word0  <= '0;
      r_mem_we <= 1'b0;
      r_mem_be <= 1'b0;
      r_mem_a  <= '0;
      r_mem_wd <= '0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_done   <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_be <= 1'b0;
      r_mem_a  <= '0;
      r_mem_wd <= '0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_size  <= size;
            r_uns   <= uns;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_k     <= 2'd0;
            if (wr) begin
              r_state  <= S_WRITE;
              r_mem_we <= 1'b1;
              r_mem_a  <= addr;
              if (FAST_ALIGNED && size[1] && (addr[1:0] == 2'b00)) begin
                r_fast   <= 1'b1;
                r_mem_be <= 1'b0;
                r_mem_wd <= wdata;
              end else begin
                r_fast   <= 1'b0;
                r_mem_be <= 1'b1;
                r_mem_wd <= {24'b0, wdata[7:0]};
              end
            end else begin
              r_state <= S_READ0;
              r_mem_a <= {addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        S_WRITE: begin
          if (r_fast || (r_k == w_last)) begin
            r_state <= S_RESP;
            r_done  <= 1'b1;
          end else begin
            r_k      <= w_k_next;
            r_mem_we <= 1'b1;
            r_mem_be <= 1'b1;
            r_mem_a  <= r_addr + ADDR_W'(w_k_next);
            r_mem_wd <= {24'b0, r_wdata[{w_k_next, 3'b000} +: 8]};
          end
        end
        S_READ0: begin
          if (w_span) begin
            r_word0 <= mem_rd;
            r_state <= S_READ1;
            r_mem_a <= r_mem_a + ADDR_W'(4);
          end else begin
            r_rdata <= extract({32'b0, mem_rd}, r_addr[1:0], r_size, r_uns);
            r_state <= S_RESP;
            r_done  <= 1'b1;
          end
        end
        S_READ1: begin
          r_rdata <= extract({mem_rd, r_word0}, r_addr[1:0], r_size, r_uns);
          r_state <= S_RESP;
          r_done  <= 1'b1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A write strobe must never reach memory while reset is asserted.
  assign mem_we = r_mem_we & ~reset;
  assign mem_be = r_mem_be;
  assign mem_a  = r_mem_a;
  assign mem_wd = r_mem_wd;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign rdata  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset, req, wr, uns;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy, done, mem_we, mem_be;
  logic [31:0]       rdata, mem_wd, mem_rd;
  logic [ADDR_W-1:0] mem_a;

  mem_access_unit #(.ADDR_W(ADDR_W), .FAST_ALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Word memory; only address bits [7:2] decode, so high addresses alias low ones.
  logic [31:0] mem [0:63];
  logic        mem_clr = 1'b0;
  logic        bd_en = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_dat = '0;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (bd_en) begin
      mem[bd_idx] <= bd_dat;
    end else if (mem_we) begin
      if (mem_be) mem[mem_a[7:2]][{mem_a[1:0], 3'b000} +: 8] <= mem_wd[7:0];
      else        mem[mem_a[7:2]] <= mem_wd;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; int at; } done_t;
  typedef struct { logic be; logic [31:0] a; logic [31:0] wd; int at; } wr_t;
  done_t done_q[$];
  wr_t   wr_q[$];
  done_t e_d;
  wr_t   e_w;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse and every write strobe must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e_d = done_q.pop_front();
          check("rdata", rdata, e_d.rdata);
          check("done_cycle", 32'(cyc), 32'(e_d.at));
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got a=%h wd=%h expected none (cycle %0d)", mem_a, mem_wd, cyc);
        end else begin
          e_w = wr_q.pop_front();
          check("wr_be", {31'b0, mem_be}, {31'b0, e_w.be});
          check("wr_a", mem_a, e_w.a);
          check("wr_wd", mem_wd, e_w.wd);
          check("wr_cycle", 32'(cyc), 32'(e_w.at));
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_idx = 6'(idx); bd_dat = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0 (cycle %0d)", cyc);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d, output int acc);
    wait_idle();
    req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
    @(posedge clk);
    #1;
    acc = cyc;
    req = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] s, input logic u, input logic [31:0] a,
                         input logic [31:0] exp, input int lat);
    int acc;
    issue(1'b0, s, u, a, 32'h0, acc);
    done_q.push_back('{rdata: exp, at: acc + lat - 1});
    last_rdata = exp;
  endtask

  task automatic do_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                          input int lat, output int acc);
    issue(1'b1, s, 1'b0, a, d, acc);
    done_q.push_back('{rdata: last_rdata, at: acc + lat - 1});
  endtask

  task automatic exp_wr(input logic be, input logic [31:0] a, input logic [31:0] wd, input int at);
    wr_q.push_back('{be: be, a: a, wd: wd, at: at});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_be", {31'b0, mem_be}, 32'h0);
    check("rst_a", mem_a, 32'h0);
    check("rst_wd", mem_wd, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;

    poke(3, 32'h44332211);
    poke(4, 32'h88776655);
    poke(63, 32'hDDCCBBAA);
    poke(0, 32'h11223344);
    poke(8, 32'h80FF7F01);

    // Loads spanning two words, including address wrap past the top.
    do_load(2'b10, 1'b0, 32'h0000000E, 32'h66554433, 3);
    do_load(2'b01, 1'b0, 32'h0000000F, 32'h00005544, 3);
    do_load(2'b10, 1'b0, 32'hFFFFFFFE, 32'h3344DDCC, 3);

    // Reset during the second byte of an unaligned word store.
    issue(1'b1, 2'b10, 1'b0, 32'h0000000D, 32'hCAFEF00D, acc);
    exp_wr(1'b1, 32'h0000000D, 32'h0000000D, acc);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_gate_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_rdata = 32'h0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_we", {31'b0, mem_we}, 32'h0);
    check("abort_a", mem_a, 32'h0);
    check("abort_wd", mem_wd, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    repeat (4) @(negedge clk);
    check("abort_mem3", mem[3], 32'h44330D11);
    check("abort_mem4", mem[4], 32'h88776655);

    // Aligned word store takes the single full-word path.
    do_store(2'b10, 32'h00000010, 32'hDEADBEEF, 2, acc);
    exp_wr(1'b0, 32'h00000010, 32'hDEADBEEF, acc);
    do_load(2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF, 2);

    // Unaligned halfword store crossing a word boundary.
    do_store(2'b01, 32'h00000013, 32'h0000A1B2, 3, acc);
    exp_wr(1'b1, 32'h00000013, 32'h000000B2, acc);
    exp_wr(1'b1, 32'h00000014, 32'h000000A1, acc + 1);
    do_load(2'b10, 1'b0, 32'h00000010, 32'hB2ADBEEF, 2);
    do_load(2'b10, 1'b0, 32'h00000014, 32'h000000A1, 2);
    do_load(2'b01, 1'b0, 32'h00000013, 32'hFFFFA1B2, 3);

    // Aligned halfword still uses two byte writes; then a single byte store.
    do_store(2'b01, 32'h00000018, 32'h00001234, 3, acc);
    exp_wr(1'b1, 32'h00000018, 32'h00000034, acc);
    exp_wr(1'b1, 32'h00000019, 32'h00000012, acc + 1);
    do_store(2'b00, 32'h0000001B, 32'hFFFFFF77, 2, acc);
    exp_wr(1'b1, 32'h0000001B, 32'h00000077, acc);
    do_load(2'b10, 1'b0, 32'h00000018, 32'h77001234, 2);

    // Sign and zero extension from a word holding 0x80FF7F01.
    do_load(2'b00, 1'b0, 32'h00000022, 32'hFFFFFFFF, 2);
    do_load(2'b00, 1'b1, 32'h00000022, 32'h000000FF, 2);
    do_load(2'b01, 1'b0, 32'h00000022, 32'hFFFF80FF, 2);
    do_load(2'b01, 1'b1, 32'h00000022, 32'h000080FF, 2);
    do_load(2'b00, 1'b0, 32'h00000021, 32'h0000007F, 2);
    do_load(2'b00, 1'b0, 32'h00000023, 32'hFFFFFF80, 2);
    do_load(2'b11, 1'b1, 32'h00000020, 32'h80FF7F01, 2);

    // Unaligned word store: four byte writes, then read it back.
    do_store(2'b10, 32'h00000025, 32'h11223344, 5, acc);
    exp_wr(1'b1, 32'h00000025, 32'h00000044, acc);
    exp_wr(1'b1, 32'h00000026, 32'h00000033, acc + 1);
    exp_wr(1'b1, 32'h00000027, 32'h00000022, acc + 2);
    exp_wr(1'b1, 32'h00000028, 32'h00000011, acc + 3);
    do_load(2'b10, 1'b0, 32'h00000025, 32'h11223344, 3);

    // req held high across two byte loads; second is taken on the first IDLE edge.
    wait_idle();
    req = 1'b1; wr = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h00000021;
    @(posedge clk);
    #1;
    acc = cyc;
    done_q.push_back('{rdata: 32'h0000007F, at: acc + 1});
    addr = 32'h00000020;
    done_q.push_back('{rdata: 32'h00000001, at: acc + 4});
    repeat (3) @(posedge clk);
    #1;
    req = 1'b0;
    check("held_accept_busy", {31'b0, busy}, 32'h1);
    last_rdata = 32'h00000001;

    wait_idle();
    repeat (4) @(negedge clk);
    check("done_q_empty", 32'(done_q.size()), 32'h0);
    check("wr_q_empty", 32'(wr_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
